adder_arbiter: RTL and testbench



---
 rtl/adder_arbiter_pkg.sv | 13 +
 rtl/adder_arbiter_rr_picker.sv | 32 +++
 rtl/an_adder.sv | 24 ++
 rtl/adder_arbiter.sv | 167 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter shared types: FSM state encoding and datapath width.
// Imported by the arbiter top; no logic lives here.
package adder_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// rr_picker: round-robin search over req_valid starting at rr_ptr.
// Outputs one-hot grant, its index and whether anyone is valid.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  always_comb begin
    logic [ID_W:0] j;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    j         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (j >= (ID_W+1)'(NUM_REQ))
        j = j - (ID_W+1)'(NUM_REQ);
      if (!any_valid && req_valid[j[ID_W-1:0]]) begin
        any_valid               = 1'b1;
        grant[j[ID_W-1:0]]      = 1'b1;
        grant_idx               = j[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/an_adder.sv
// anAdder: the shared ripple-carry adder (sum = a + b + cin).
// Purely combinational; carry ripples bit by bit.
module anAdder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic cy;
    cy  = cin;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one 32-bit adder among NUM_REQ.
// Define ADDER_ARB_OVF_EN to add the registered signed-overflow output.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_sum,
  output logic                    rsp_cout
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                    rsp_ovf
`endif
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                sub_q, sub_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic                rsp_cout_q, rsp_cout_d;
`ifdef ADDER_ARB_OVF_EN
  logic                rsp_ovf_q, rsp_ovf_d;
`endif

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_valid;
  logic [DATA_W-1:0]   b_eff;
  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Subtract is a + ~b + 1 through the same adder.
  assign b_eff = sub_q ? ~b_q : b_q;

  anAdder #(
    .W (DATA_W)
  ) u_add (
    .a    (a_q),
    .b    (b_eff),
    .cin  (sub_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign req_ready = (state_q == ST_IDLE) ? grant : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
`ifdef ADDER_ARB_OVF_EN
    rsp_ovf_d   = rsp_ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
              a_d   = req_a[i*DATA_W +: DATA_W];
              b_d   = req_b[i*DATA_W +: DATA_W];
              sub_d = req_sub[i];
            end
          end
          id_d = grant_idx;
          if (grant_idx == ID_W'(NUM_REQ-1))
            rr_ptr_d = '0;
          else
            rr_ptr_d = grant_idx + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
`ifdef ADDER_ARB_OVF_EN
        rsp_ovf_d   = (a_q[31] == b_eff[31]) &&
                      (add_sum[31] != a_q[31]);
`endif
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
`ifdef ADDER_ARB_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level model checked every cycle,
// plus directed operations with literal expected results.
module tb_adder_arbiter;

  localparam int N   = 2;
  localparam int IDW = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a = '0;
  logic [N*32-1:0]   req_b = '0;
  logic [N-1:0]      req_sub = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_sum;
  logic              rsp_cout;
`ifdef ADDER_ARB_OVF_EN
  logic              rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_stage = 0;
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  int          m_id    = 0;
  logic [31:0] m_sum   = '0;
  logic        m_cout  = 1'b0;
  logic        m_ovf   = 1'b0;
  int          p_id    = 0;
  logic [31:0] p_sum   = '0;
  logic        p_cout  = 1'b0;
  logic        p_ovf   = 1'b0;

  function automatic int pick(logic [N-1:0] v, int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic compute(input logic [31:0] a, input logic [31:0] b,
                         input logic s, output logic [31:0] sum,
                         output logic c, output logic o);
    logic [32:0] w;
    longint r;
    if (s) begin
      sum = a - b;
      c   = (a >= b);
      r   = longint'(signed'(a)) - longint'(signed'(b));
    end else begin
      w   = {1'b0, a} + {1'b0, b};
      sum = w[31:0];
      c   = w[32];
      r   = longint'(signed'(a)) + longint'(signed'(b));
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  always @(posedge clk) begin
    int g;
    if (reset) begin
      m_stage = 0; m_ptr = 0; m_valid = 1'b0;
      m_id = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      case (m_stage)
        0: begin
          g = pick(req_valid, m_ptr);
          if (g >= 0) begin
            compute(req_a[g*32 +: 32], req_b[g*32 +: 32], req_sub[g],
                    p_sum, p_cout, p_ovf);
            p_id    = g;
            m_ptr   = (g + 1) % N;
            m_stage = 1;
          end
        end
        1: begin
          m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
          m_id = p_id; m_valid = 1'b1; m_stage = 2;
        end
        default: begin
          if (rsp_ready) begin
            m_valid = 1'b0;
            m_stage = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] er;
    int g;
    er = '0;
    if (m_stage == 0) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) er[g] = 1'b1;
    end
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_sum", rsp_sum, m_sum);
    chk("rsp_cout", rsp_cout, m_cout);
`ifdef ADDER_ARB_OVF_EN
    chk("rsp_ovf", rsp_ovf, m_ovf);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(int r, logic [31:0] a, logic [31:0] b, logic s,
                        logic [31:0] es, logic ec, logic eo, string nm);
    int  n;
    bit  ok;
    @(posedge clk); #1;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_sub[r]        = s;
    req_valid[r]      = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1;
    end
    chk({nm, "_grant"}, ok, 1);
    @(posedge clk); #1;
    req_valid[r]      = 1'b0;
    req_a[r*32 +: 32] = ~a;
    req_b[r*32 +: 32] = ~b;
    n = 0; ok = 0;
    while (n < 10 && !ok) begin
      @(negedge clk);
      n++;
      if (rsp_valid) ok = 1;
    end
    chk({nm, "_latency"}, n, 2);
    chk({nm, "_id"}, rsp_id, r);
    chk({nm, "_sum"}, rsp_sum, es);
    chk({nm, "_cout"}, rsp_cout, ec);
`ifdef ADDER_ARB_OVF_EN
    chk({nm, "_ovf"}, rsp_ovf, eo);
`else
    if (eo === 1'bx) $display("note: ovf not built");
`endif
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int ids[4];
    logic [31:0] sums[4];
    logic [31:0] held;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_sum", rsp_sum, 32'h0);
    chk("reset_valid", rsp_valid, 1'b0);

    run_op(0, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, "add_ovf");
    run_op(1, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_neg");
    run_op(1, 32'd7, 32'd5, 1'b1, 32'd2, 1'b1, 1'b0, "sub_pos");
    run_op(0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, "wrap");
    run_op(1, 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf");

    // Fairness: both requesters held valid from a fresh pointer.
    pulse_reset();
    req_a = {32'd50, 32'd100};
    req_b = {32'd8, 32'd1};
    req_sub = 2'b10;
    req_valid = 2'b11;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids[cnt]  = rsp_id;
        sums[cnt] = rsp_sum;
        cnt++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("fair_count", cnt, 4);
    chk("fair_id0", ids[0], 0);
    chk("fair_id1", ids[1], 1);
    chk("fair_id2", ids[2], 0);
    chk("fair_id3", ids[3], 1);
    chk("fair_sum0", sums[0], 32'd101);
    chk("fair_sum1", sums[1], 32'd42);
    chk("fair_sum2", sums[2], 32'd101);

    // Backpressure with the other requester waiting.
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_a = {32'd20, 32'd10};
    req_b = {32'd4, 32'd3};
    req_sub = 2'b00;
    req_valid = 2'b11;
    cnt = 0;
    while (cnt < 10 && !rsp_valid) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_valid", rsp_valid, 1'b1);
    chk("bp_id", rsp_id, 0);
    held = rsp_sum;
    chk("bp_sum", held, 32'd13);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_sum", rsp_sum, 32'd13);
      chk("bp_hold_ready", req_ready, 2'b00);
      chk("bp_hold_valid", rsp_valid, 1'b1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_drop", rsp_valid, 1'b0);
    chk("bp_next_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);

    // Reset while the accepted operation sits in EXEC.
    #1;
    req_a = {32'd0, 32'd1};
    req_b = {32'd0, 32'd2};
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 1'b0);
    end
    chk("rst_sum", rsp_sum, 32'h0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_ptr", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
